// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared types and helpers for the recirculating shift-register bank.
//   state_t : clear-sequencer state (IDLE / CLEAR)
//   POS_W   : width of the position / pointer counters for a given depth
// Optional feature macro used by the bank: SHIFT_REG_PARITY_EN
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Counter width for 0..depth-1; never narrower than one bit.
    function automatic int unsigned POS_W(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_reg_ring.sv
// -----------------------------------------------------------------------------
// shift_reg_ring
// DEPTH x DW circular buffer with a single read/write pointer. On a shift the
// slot under the pointer is read (oldest word) and overwritten with the new
// word, then the pointer advances, so the word read is always the one written
// exactly DEPTH shifts earlier.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears all slots, pointer)
//   i_shift    in   advance one stage this cycle
//   i_wr_data  in   DW  word entered on a shift
//   o_rd_data  out  DW  oldest word (combinational from storage)
//   o_nxt_data out  DW  word that becomes oldest after the next shift
//                       (only with SHIFT_REG_PARITY_EN)
// -----------------------------------------------------------------------------
module shift_reg_ring
    import shift_reg_pkg::*;
#(
    parameter int unsigned DW    = 6,
    parameter int unsigned DEPTH = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_rd_data
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic [DW-1:0] o_nxt_data
`endif
);

    localparam int unsigned PW = POS_W(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_shift) begin
            r_mem[r_ptr] <= i_wr_data;
            r_ptr        <= w_ptr_nxt;
        end
    end

    assign o_rd_data = r_mem[r_ptr];

`ifdef SHIFT_REG_PARITY_EN
    // DEPTH >= 2, so the next slot is never the one being written this shift.
    assign o_nxt_data = r_mem[w_ptr_nxt];
`endif

endmodule : shift_reg_ring

// File: rtl/shift_reg_bank.sv
// -----------------------------------------------------------------------------
// shift_reg_bank
// Recirculating WIDTH x DEPTH shift-register character store with shift enable,
// position counter / wrap pulse and a one-revolution clear sequencer.
// Optional feature macro: SHIFT_REG_PARITY_EN (per-stage even parity + par_err)
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, overrides everything
//   shift_en  in   advance one stage this cycle
//   rc        in   1 = recirculate dout, 0 = load din
//   din       in   WIDTH  word entered when rc=0
//   clr_req   in   pulse: start a one-revolution clear (ignored while busy)
//   dout      out  WIDTH  oldest word
//   pos       out  POS_W(DEPTH)  shifts since reset, mod DEPTH
//   wrap      out  one-cycle pulse after pos wraps to 0
//   busy      out  clear sequence in progress
//   par_err   out  parity error on current dout (SHIFT_REG_PARITY_EN only)
// -----------------------------------------------------------------------------
module shift_reg_bank
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic                      rc,
    input  logic [WIDTH-1:0]          din,
    input  logic                      clr_req,
    output logic [WIDTH-1:0]          dout,
    output logic [POS_W(DEPTH)-1:0]   pos,
    output logic                      wrap,
    output logic                      busy
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic                      par_err
`endif
);

    localparam int unsigned PW = POS_W(DEPTH);
`ifdef SHIFT_REG_PARITY_EN
    localparam int unsigned DW = WIDTH + 1;
`else
    localparam int unsigned DW = WIDTH;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_clr_cnt;
    logic [PW-1:0] r_pos;
    logic          r_wrap;
    logic [DW-1:0] w_wr_data;
    logic [DW-1:0] w_rd_data;
`ifdef SHIFT_REG_PARITY_EN
    logic [DW-1:0] w_nxt_data;
    logic          r_par_err;
`endif

    // ---------------------------------------------------------------- storage
    shift_reg_ring #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_shift   (shift_en),
        .i_wr_data (w_wr_data),
        .o_rd_data (w_rd_data)
`ifdef SHIFT_REG_PARITY_EN
        ,
        .o_nxt_data(w_nxt_data)
`endif
    );

    // Entered word: zero while clearing, else recirculated or loaded.
    // Recirculation copies the stored parity bit (MSB) unchanged.
    always_comb begin
        w_wr_data = '0;
        if (r_state == IDLE) begin
`ifdef SHIFT_REG_PARITY_EN
            w_wr_data = rc ? w_rd_data : {^din, din};
`else
            w_wr_data = rc ? w_rd_data : din;
`endif
        end
    end

    assign dout = w_rd_data[WIDTH-1:0];

    // ------------------------------------------------------- clear sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (shift_en && (r_clr_cnt == PW'(DEPTH - 1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counts clear shifts; held at 0 in IDLE so each clear starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE)) begin
            r_clr_cnt <= '0;
        end else if (shift_en) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign busy = (r_state == CLEAR);

    // ------------------------------------------------------- position / wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (shift_en) begin
                if (r_pos == PW'(DEPTH - 1)) begin
                    r_pos  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_pos <= r_pos + 1'b1;
                end
            end
        end
    end

    assign pos  = r_pos;
    assign wrap = r_wrap;

    // ---------------------------------------------------------------- parity
`ifdef SHIFT_REG_PARITY_EN
    // Checked on the word that becomes dout after this shift, so par_err
    // lines up with the dout it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (shift_en) begin
            r_par_err <= ^w_nxt_data;
        end
    end

    assign par_err = r_par_err;
`endif

endmodule : shift_reg_bank
